// File: rtl/adc_sample_ctrl_if.sv
// ADC conversion handshake bundle: the controller drives start/oe,
// the converter returns end-of-conversion and the parallel result.
interface adc_sample_ctrl_if #(
  parameter int DATA_W = 12
) ();
  logic              adc_start;
  logic              adc_oe;
  logic              adc_eoc;
  logic [DATA_W-1:0] adc_data;

  modport master (
    output adc_start,
    output adc_oe,
    input  adc_eoc,
    input  adc_data
  );

  modport slave (
    input  adc_start,
    input  adc_oe,
    output adc_eoc,
    output adc_data
  );
endinterface

// File: rtl/adc_sample_ctrl.sv
// Periodic ADC conversion sequencer with box-car averaging of 2^AVG_LOG2
// results; emits one filtered sample per window as a single-cycle pulse.
module adc_sample_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int START_WIDTH   = 2,
  parameter int OE_HOLD       = 2,
  parameter int TIMEOUT       = 4096,
  parameter int AVG_LOG2      = 2,
  parameter int DATA_W        = 12
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  adc_sample_ctrl_if.master   adc,
  output logic [DATA_W-1:0]   raw_data,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sample_valid,
  output logic                overrun,
  output logic                timeout_err,
  input  logic                err_clr
);
  localparam int PER_W   = $clog2(SAMPLE_PERIOD);
  localparam int TMO_W   = $clog2(TIMEOUT);
  localparam int SUB_MAX = (START_WIDTH > OE_HOLD) ? START_WIDTH : OE_HOLD;
  localparam int SUB_W   = $clog2(SUB_MAX);
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int WIN_W   = AVG_LOG2 + 1;

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [SUB_W-1:0] START_LAST = SUB_W'(START_WIDTH - 1);
  localparam logic [SUB_W-1:0] OE_LAST    = SUB_W'(OE_HOLD - 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_LOW, WAIT_HIGH, READ, OUT
  } state_t;

  state_t            state_q,   state_d;
  logic [PER_W-1:0]  per_q,     per_d;
  logic [TMO_W-1:0]  tmo_q,     tmo_d;
  logic [SUB_W-1:0]  sub_q,     sub_d;
  logic [ACC_W-1:0]  acc_q,     acc_d;
  logic [WIN_W-1:0]  win_q,     win_d;
  logic              start_q,   start_d;
  logic              oe_q,      oe_d;
  logic [DATA_W-1:0] raw_q,     raw_d;
  logic [DATA_W-1:0] sample_q,  sample_d;
  logic              valid_q,   valid_d;
  logic              overrun_q, overrun_d;
  logic              tmo_err_q, tmo_err_d;

  logic             tick;
  logic             tmo_hit;
  logic [ACC_W-1:0] acc_sum;

  assign tick    = enable && (per_q == PER_LAST);
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign acc_sum = acc_q + ACC_W'(adc.adc_data);

  always_comb begin
    state_d   = state_q;
    per_d     = (!enable || tick) ? '0 : per_q + PER_W'(1);
    tmo_d     = tmo_q;
    sub_d     = sub_q;
    acc_d     = acc_q;
    win_d     = win_q;
    start_d   = 1'b0;
    oe_d      = 1'b0;
    raw_d     = raw_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    tmo_err_d = tmo_err_q;

    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = START;
          start_d = 1'b1;
          sub_d   = '0;
        end
      end
      START: begin
        if (sub_q == START_LAST) begin
          state_d = WAIT_LOW;
          tmo_d   = '0;
        end else begin
          start_d = 1'b1;
          sub_d   = sub_q + SUB_W'(1);
        end
      end
      WAIT_LOW: begin
        if (!adc.adc_eoc) begin
          state_d = WAIT_HIGH;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
          acc_d     = '0;
          win_d     = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (adc.adc_eoc) begin
          state_d = READ;
          oe_d    = 1'b1;
          sub_d   = '0;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
          acc_d     = '0;
          win_d     = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      READ: begin
        if (sub_q == OE_LAST) begin
          raw_d = adc.adc_data;
          acc_d = acc_sum;
          win_d = win_q + WIN_W'(1);
          // Publish on the capture edge so the pulse lands in the OUT cycle.
          if (win_q == WIN_LAST) begin
            state_d  = OUT;
            sample_d = DATA_W'(acc_sum >> AVG_LOG2);
            valid_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          oe_d  = 1'b1;
          sub_d = sub_q + SUB_W'(1);
        end
      end
      OUT: begin
        acc_d   = '0;
        win_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_clr) begin
      overrun_d = 1'b0;
      tmo_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      per_q     <= '0;
      tmo_q     <= '0;
      sub_q     <= '0;
      acc_q     <= '0;
      win_q     <= '0;
      start_q   <= 1'b0;
      oe_q      <= 1'b0;
      raw_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      tmo_q     <= tmo_d;
      sub_q     <= sub_d;
      acc_q     <= acc_d;
      win_q     <= win_d;
      start_q   <= start_d;
      oe_q      <= oe_d;
      raw_q     <= raw_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign adc.adc_start = start_q;
  assign adc.adc_oe    = oe_q;
  assign raw_data      = raw_q;
  assign sample_data   = sample_q;
  assign sample_valid  = valid_q;
  assign overrun       = overrun_q;
  assign timeout_err   = tmo_err_q;
endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench: a pass-through instance and a 4-sample averaging instance,
// each driven by a small behavioural ADC model.
module tb_adc_sample_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        rstn_pt = 1'b0, en_pt = 1'b0, clr_pt = 1'b0;
  logic        rstn_avg = 1'b0, en_avg = 1'b0, clr_avg = 1'b0;
  logic [11:0] raw_pt, samp_pt, raw_avg, samp_avg;
  logic        valid_pt, ovr_pt, tmo_pt, valid_avg, ovr_avg, tmo_avg;

  adc_sample_ctrl_if #(.DATA_W(12)) if_pt ();
  adc_sample_ctrl_if #(.DATA_W(12)) if_avg ();

  adc_sample_ctrl #(.SAMPLE_PERIOD(20), .START_WIDTH(2), .OE_HOLD(2),
                    .TIMEOUT(64), .AVG_LOG2(0), .DATA_W(12)) u_pt (
    .clk(clk), .rstn(rstn_pt), .enable(en_pt), .adc(if_pt.master),
    .raw_data(raw_pt), .sample_data(samp_pt), .sample_valid(valid_pt),
    .overrun(ovr_pt), .timeout_err(tmo_pt), .err_clr(clr_pt)
  );

  adc_sample_ctrl #(.SAMPLE_PERIOD(20), .START_WIDTH(2), .OE_HOLD(2),
                    .TIMEOUT(64), .AVG_LOG2(2), .DATA_W(12)) u_avg (
    .clk(clk), .rstn(rstn_avg), .enable(en_avg), .adc(if_avg.master),
    .raw_data(raw_avg), .sample_data(samp_avg), .sample_valid(valid_avg),
    .overrun(ovr_avg), .timeout_err(tmo_avg), .err_clr(clr_avg)
  );

  // ADC models: EOC drops the cycle after start falls and stays low conv_* cycles.
  logic [11:0] data_pt = 12'd0, data_avg = 12'd0;
  logic        eoc_pt = 1'b1, eoc_avg = 1'b1;
  int          conv_pt = 8, conv_avg = 8;
  bit          stuck_avg = 1'b0;
  bit          armed_pt = 1'b0, armed_avg = 1'b0;
  int          cnt_pt = 0, cnt_avg = 0;
  logic        poe_pt = 1'b0, poe_avg = 1'b0;
  int          ncap_avg = 0, nvalid_avg = 0, nsync_avg = 0;
  logic [11:0] last_samp_avg = 12'd0;

  assign if_pt.adc_eoc   = eoc_pt;
  assign if_pt.adc_data  = data_pt;
  assign if_avg.adc_eoc  = eoc_avg;
  assign if_avg.adc_data = data_avg;

  always @(negedge clk) begin
    if (if_pt.adc_start === 1'b1) begin
      armed_pt = 1'b1;
    end else if (armed_pt) begin
      armed_pt = 1'b0;
      eoc_pt   = 1'b0;
      cnt_pt   = conv_pt;
    end else if (cnt_pt > 0) begin
      cnt_pt--;
      if (cnt_pt == 0) eoc_pt = 1'b1;
    end
    if (poe_pt === 1'b1 && if_pt.adc_oe === 1'b0)
      $display("[%0t] pt  capture raw=%0h", $time, raw_pt);
    poe_pt = if_pt.adc_oe;
  end

  always @(negedge clk) begin
    if (if_avg.adc_start === 1'b1) begin
      armed_avg = 1'b1;
    end else if (armed_avg) begin
      armed_avg = 1'b0;
      if (!stuck_avg) begin
        eoc_avg = 1'b0;
        cnt_avg = conv_avg;
      end
    end else if (cnt_avg > 0) begin
      cnt_avg--;
      if (cnt_avg == 0) eoc_avg = 1'b1;
    end
    if (poe_avg === 1'b1 && if_avg.adc_oe === 1'b0) begin
      ncap_avg++;
      if (valid_avg === 1'b1) nsync_avg++;
      $display("[%0t] avg capture raw=%0d", $time, raw_avg);
    end
    if (valid_avg === 1'b1) begin
      nvalid_avg++;
      last_samp_avg = samp_avg;
      $display("[%0t] avg sample_valid sample_data=%0d", $time, samp_avg);
    end
    poe_avg = if_avg.adc_oe;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_caps(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ncap_avg >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rstn_pt = 1'b0; rstn_avg = 1'b0;
    repeat (3) step();
    n_vec++;
    if ({if_pt.adc_start, if_pt.adc_oe, valid_pt, ovr_pt, tmo_pt} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_pt_ctrl: got %b expected 00000",
               {if_pt.adc_start, if_pt.adc_oe, valid_pt, ovr_pt, tmo_pt});
    end
    n_vec++;
    if ({if_avg.adc_start, if_avg.adc_oe, valid_avg, ovr_avg, tmo_avg} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_avg_ctrl: got %b expected 00000",
               {if_avg.adc_start, if_avg.adc_oe, valid_avg, ovr_avg, tmo_avg});
    end
    n_vec++;
    if ({raw_pt, samp_pt, raw_avg, samp_avg} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", {raw_pt, samp_pt, raw_avg, samp_avg});
    end
    rstn_pt = 1'b1; rstn_avg = 1'b1;
  endtask

  task automatic test_passthrough();
    int   rises = 0, last_rise = 0, nval = 0;
    logic ps = 1'b0;
    data_pt = 12'hABC;
    en_pt   = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      step();
      if (if_pt.adc_start === 1'b1 && ps === 1'b0) begin
        n_vec++;
        if (rises == 0) begin
          if (i != 20) begin
            n_err++;
            $display("FAIL pt_first_start: got cycle %0d expected 20", i);
          end
        end else if (i - last_rise != 20) begin
          n_err++;
          $display("FAIL pt_start_period: got %0d expected 20", i - last_rise);
        end
        last_rise = i;
        rises++;
      end
      if (if_pt.adc_start === 1'b0 && ps === 1'b1) begin
        n_vec++;
        if (i - last_rise != 2) begin
          n_err++;
          $display("FAIL pt_start_width: got %0d expected 2", i - last_rise);
        end
      end
      if (valid_pt === 1'b1) begin
        nval++;
        n_vec++;
        if (samp_pt !== 12'hABC) begin
          n_err++;
          $display("FAIL pt_sample: got %h expected abc", samp_pt);
        end
      end
      ps = if_pt.adc_start;
    end
    en_pt = 1'b0;
    n_vec++;
    if (rises != 5) begin
      n_err++;
      $display("FAIL pt_start_count: got %0d expected 5", rises);
    end
    n_vec++;
    if (nval != 4) begin
      n_err++;
      $display("FAIL pt_valid_count: got %0d expected 4", nval);
    end
    n_vec++;
    if ({ovr_pt, tmo_pt} !== 2'b00 || raw_pt !== 12'hABC) begin
      n_err++;
      $display("FAIL pt_flags_raw: got flags %b raw %h expected 00 abc", {ovr_pt, tmo_pt}, raw_pt);
    end
  endtask

  task automatic test_average();
    logic [11:0] vals [4] = '{12'd100, 12'd200, 12'd300, 12'd401};
    int base_c = ncap_avg, base_v = nvalid_avg, base_s = nsync_avg;
    bit ok;
    en_avg = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_avg = vals[k];
      wait_caps(base_c + k + 1, 100, ok);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL avg_capture_wait: got no capture %0d expected one within 100 cycles", k + 1);
      end
      if (k < 3) begin
        n_vec++;
        if (nvalid_avg != base_v) begin
          n_err++;
          $display("FAIL avg_early_valid: got %0d pulses after %0d captures expected 0",
                   nvalid_avg - base_v, k + 1);
        end
      end
    end
    step();
    en_avg = 1'b0;
    n_vec++;
    if (nvalid_avg - base_v != 1 || nsync_avg - base_s != 1) begin
      n_err++;
      $display("FAIL avg_valid_pulse: got %0d pulses (%0d aligned) expected 1 (1)",
               nvalid_avg - base_v, nsync_avg - base_s);
    end
    n_vec++;
    if (last_samp_avg !== 12'd250) begin
      n_err++;
      $display("FAIL avg_sample: got %0d expected 250", last_samp_avg);
    end
    n_vec++;
    if (raw_avg !== 12'd401 || samp_avg !== 12'd250) begin
      n_err++;
      $display("FAIL avg_hold: got raw %0d sample %0d expected 401 250", raw_avg, samp_avg);
    end
    settle(30);
  endtask

  task automatic test_timeout();
    int   base_c, base_v, fall_i = -1, noe = 0;
    bit   ok, done = 1'b0;
    logic ps;
    en_avg   = 1'b1;
    data_avg = 12'd4000;
    wait_caps(ncap_avg + 1, 100, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL tmo_pre_capture: got no capture expected one within 100 cycles");
    end
    stuck_avg = 1'b1;
    ps = if_avg.adc_start;
    for (int i = 0; i < 200; i++) begin
      step();
      if (if_avg.adc_oe === 1'b1) noe++;
      if (ps === 1'b1 && if_avg.adc_start === 1'b0 && fall_i < 0) fall_i = i;
      if (fall_i >= 0 && i == fall_i + 63) begin
        n_vec++;
        if (tmo_avg !== 1'b0) begin
          n_err++;
          $display("FAIL tmo_early: got %b at 63 cycles expected 0", tmo_avg);
        end
      end
      if (fall_i >= 0 && i == fall_i + 64) begin
        n_vec++;
        if (tmo_avg !== 1'b1) begin
          n_err++;
          $display("FAIL tmo_set: got %b at 64 cycles expected 1", tmo_avg);
        end
        done = 1'b1;
        break;
      end
      ps = if_avg.adc_start;
    end
    n_vec++;
    if (!done || noe != 0) begin
      n_err++;
      $display("FAIL tmo_sequence: got done=%0d oe_cycles=%0d expected 1 0", done, noe);
    end
    n_vec++;
    if (ovr_avg !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_overrun: got %b expected 1", ovr_avg);
    end
    stuck_avg = 1'b0;
    data_avg  = 12'd8;
    clr_avg   = 1'b1;
    step();
    clr_avg = 1'b0;
    n_vec++;
    if ({ovr_avg, tmo_avg} !== 2'b00) begin
      n_err++;
      $display("FAIL err_clr: got %b expected 00", {ovr_avg, tmo_avg});
    end
    base_c = ncap_avg;
    base_v = nvalid_avg;
    wait_caps(base_c + 3, 200, ok);
    n_vec++;
    if (!ok || nvalid_avg != base_v) begin
      n_err++;
      $display("FAIL tmo_window_discard: got ok=%0d pulses=%0d after 3 captures expected 1 0",
               ok, nvalid_avg - base_v);
    end
    wait_caps(base_c + 4, 100, ok);
    step();
    n_vec++;
    if (!ok || nvalid_avg - base_v != 1 || last_samp_avg !== 12'd8) begin
      n_err++;
      $display("FAIL tmo_fresh_window: got pulses=%0d sample=%0d expected 1 8",
               nvalid_avg - base_v, last_samp_avg);
    end
    en_avg = 1'b0;
    settle(30);
  endtask

  task automatic test_overrun();
    int   rises = 0, base_c = ncap_avg;
    logic ps = 1'b0;
    conv_avg = 30;
    data_avg = 12'd1234;
    en_avg   = 1'b1;
    for (int i = 1; i <= 58; i++) begin
      step();
      if (if_avg.adc_start === 1'b1 && ps === 1'b0) rises++;
      ps = if_avg.adc_start;
      if (i == 39) begin
        n_vec++;
        if (ovr_avg !== 1'b0) begin
          n_err++;
          $display("FAIL ovr_early: got %b expected 0", ovr_avg);
        end
      end
      if (i == 40) begin
        n_vec++;
        if (ovr_avg !== 1'b1) begin
          n_err++;
          $display("FAIL ovr_set: got %b expected 1", ovr_avg);
        end
      end
    end
    en_avg = 1'b0;
    n_vec++;
    if (rises != 1) begin
      n_err++;
      $display("FAIL ovr_tick_dropped: got %0d starts expected 1", rises);
    end
    n_vec++;
    if (ncap_avg - base_c != 1 || raw_avg !== 12'd1234) begin
      n_err++;
      $display("FAIL ovr_capture: got caps=%0d raw=%0d expected 1 1234", ncap_avg - base_c, raw_avg);
    end
    conv_avg = 8;
    settle(10);
  endtask

  task automatic test_reset_in_read();
    int base_c, base_v;
    bit ok, seen = 1'b0;
    data_avg = 12'd999;
    en_avg   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (if_avg.adc_oe === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL rst_read_wait: got no adc_oe expected one within 100 cycles");
    end
    rstn_avg = 1'b0;
    step();
    n_vec++;
    if ({if_avg.adc_start, if_avg.adc_oe, valid_avg, ovr_avg, tmo_avg} !== 5'b0 ||
        raw_avg !== 12'd0 || samp_avg !== 12'd0) begin
      n_err++;
      $display("FAIL rst_read_outputs: got ctrl %b raw %0d sample %0d expected 00000 0 0",
               {if_avg.adc_start, if_avg.adc_oe, valid_avg, ovr_avg, tmo_avg}, raw_avg, samp_avg);
    end
    rstn_avg = 1'b1;
    data_avg = 12'd20;
    step();
    base_c = ncap_avg;
    base_v = nvalid_avg;
    wait_caps(base_c + 3, 200, ok);
    n_vec++;
    if (!ok || nvalid_avg != base_v) begin
      n_err++;
      $display("FAIL rst_acc_cleared: got ok=%0d pulses=%0d after 3 captures expected 1 0",
               ok, nvalid_avg - base_v);
    end
    wait_caps(base_c + 4, 100, ok);
    step();
    n_vec++;
    if (!ok || nvalid_avg - base_v != 1 || last_samp_avg !== 12'd20) begin
      n_err++;
      $display("FAIL rst_new_window: got pulses=%0d sample=%0d expected 1 20",
               nvalid_avg - base_v, last_samp_avg);
    end
    en_avg = 1'b0;
    settle(30);
  endtask

  task automatic test_enable_drop();
    int   base_c = ncap_avg, base_v, rises = 0, first = -1;
    bit   ok, seen = 1'b0;
    logic ps;
    data_avg = 12'd40;
    en_avg   = 1'b1;
    wait_caps(base_c + 1, 100, ok);
    for (int i = 0; i < 60; i++) begin
      step();
      if (if_avg.adc_eoc === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    step();
    step();
    en_avg = 1'b0;
    n_vec++;
    if (!ok || !seen) begin
      n_err++;
      $display("FAIL endrop_setup: got cap=%0d eoc_low=%0d expected 1 1", ok, seen);
    end
    wait_caps(base_c + 2, 60, ok);
    n_vec++;
    if (!ok || raw_avg !== 12'd40) begin
      n_err++;
      $display("FAIL endrop_completes: got ok=%0d raw=%0d expected 1 40", ok, raw_avg);
    end
    base_v = nvalid_avg;
    ps = if_avg.adc_start;
    for (int i = 0; i < 60; i++) begin
      step();
      if (if_avg.adc_start === 1'b1 && ps === 1'b0) rises++;
      ps = if_avg.adc_start;
    end
    n_vec++;
    if (rises != 0 || nvalid_avg != base_v) begin
      n_err++;
      $display("FAIL endrop_idle: got starts=%0d pulses=%0d expected 0 0", rises, nvalid_avg - base_v);
    end
    data_avg = 12'd80;
    en_avg   = 1'b1;
    ps       = if_avg.adc_start;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (if_avg.adc_start === 1'b1 && ps === 1'b0 && first < 0) first = i;
      ps = if_avg.adc_start;
    end
    n_vec++;
    if (first != 20) begin
      n_err++;
      $display("FAIL endrop_resume_phase: got first start at %0d expected 20", first);
    end
    wait_caps(base_c + 4, 100, ok);
    step();
    n_vec++;
    if (!ok || nvalid_avg - base_v != 1 || last_samp_avg !== 12'd60) begin
      n_err++;
      $display("FAIL endrop_window_kept: got pulses=%0d sample=%0d expected 1 60",
               nvalid_avg - base_v, last_samp_avg);
    end
    en_avg = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_average();
    test_timeout();
    test_overrun();
    test_reset_in_read();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adc_sample_ctrl.md
Name: adc_sample_ctrl

Overview:
- Drives the ADC conversion handshake (start / EOC / OE) on a fixed sample period.
- Captures each 12-bit conversion result and box-car averages 2^AVG_LOG2 results.
- Presents one filtered sample per averaging window to the downstream PID stage as a single-cycle valid pulse.
- Sits between the ADC front-end controller and the PID error computation.

Parameters:
- SAMPLE_PERIOD, 1000: clk cycles between conversion starts (≥ 16).
- START_WIDTH, 2: clk cycles adc_start is held high (≥ 1).
- OE_HOLD, 2: clk cycles adc_oe is held high; data captured on the last one (≥ 2).
- TIMEOUT, 4096: max cycles waiting for each EOC edge.
- AVG_LOG2, 2: log2 of averaging window (0..4; 0 = pass-through).
- DATA_W, 12: ADC data width.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- enable  in  1  run periodic sampling
- adc_eoc  in  1  ADC end-of-conversion (high = idle/done, low = converting)
- adc_data  in  DATA_W  ADC result, valid while adc_oe high
- adc_start  out  1  conversion start pulse to ADC
- adc_oe  out  1  output enable to ADC
- raw_data  out  DATA_W  last captured unfiltered result
- sample_data  out  DATA_W  averaged result
- sample_valid  out  1  one-cycle pulse, sample_data updated
- overrun  out  1  sticky: period tick arrived while a transaction was busy
- timeout_err  out  1  sticky: EOC edge not seen within TIMEOUT
- err_clr  in  1  clears overrun and timeout_err (takes priority over setting in the same cycle)

Behaviour:
- Reset (rstn low at posedge clk): all outputs 0; state IDLE; period counter, timeout counter, accumulator and window count cleared.
- Period counter: counts 0..SAMPLE_PERIOD-1 and wraps while enable=1. It is held at 0 while enable=0. A tick is issued when count==SAMPLE_PERIOD-1.
- Tick in IDLE starts a transaction. Tick in any other state is dropped and sets overrun.
- State machine:
  - IDLE: go to START on tick.
  - START: adc_start=1 for START_WIDTH cycles, then go to WAIT_LOW.
  - WAIT_LOW: wait for adc_eoc==0 (conversion running), then go to WAIT_HIGH.
  - WAIT_HIGH: wait for adc_eoc==1, then go to READ.
  - READ: adc_oe=1 for OE_HOLD cycles. On the last cycle, capture adc_data into raw_data and add it to the accumulator. Then go to IDLE, or to OUT if the window is full.
  - OUT: sample_data = acc >> AVG_LOG2 (truncating). sample_valid=1 for this single cycle. Accumulator and window count cleared. Go to IDLE.
- Timing: adc_start and adc_oe are registered outputs. adc_oe falls the cycle after capture. sample_valid is asserted the cycle after the window-completing capture.
- Accumulator is DATA_W+AVG_LOG2 bits wide and cannot overflow.
- Timeout:
  - Counter is cleared on entry to WAIT_LOW and again on entry to WAIT_HIGH.
  - If it reaches TIMEOUT-1 in either state: set timeout_err, discard the partial window (acc and count cleared), return to IDLE. No adc_oe is issued.
- enable deasserted mid-transaction: the transaction completes normally, including OUT if due. No further ticks. The partial window is retained for when enable returns.
- A same-cycle tick and timeout sets both flags; the FSM returns to IDLE and the tick is dropped.
- raw_data and sample_data hold their values until the next update.

Test Plan:
- AVG_LOG2=0, SAMPLE_PERIOD=20, ADC model returns 12'hABC with EOC low for 8 cycles -> adc_start high 2 cycles every 20; sample_valid pulses with sample_data=12'hABC each period; no flags.
- AVG_LOG2=2, inputs 100,200,300,401 -> exactly one sample_valid after the 4th capture with sample_data=250 (1001>>2, truncated); raw_data=401.
- ADC model never drops EOC, TIMEOUT=64 -> timeout_err=1 64 cycles after WAIT_LOW entry; adc_oe never asserted; next tick starts a fresh window; err_clr clears the flag.
- Conversion stretched to 30 cycles with SAMPLE_PERIOD=20 -> overrun=1; the tick is dropped; the in-flight sample is still captured correctly.
- rstn low during READ (adc_oe high) -> next cycle all outputs 0, state IDLE, accumulator cleared; the first post-reset window averages only new samples.
- enable dropped during WAIT_HIGH -> the current capture completes; no adc_start afterwards; re-enable resumes with period counter from 0 and the partial window preserved.
